// File: rtl/sram_pkg.sv
// Shared definitions for the external 16-bit SRAM bus: read-state encoding,
// default bus widths, read-latency bounds and byte-lane indices.
package sram_pkg;

    localparam int SRAM_ADDR_W  = 18;
    localparam int SRAM_DATA_W  = 16;

    localparam int READ_LAT_MIN = 1;
    localparam int READ_LAT_MAX = 7;

    localparam int LANE_W    = 8;
    localparam int NUM_LANES = 2;
    localparam int LANE_LO   = 0;
    localparam int LANE_HI   = 1;

    typedef enum logic [1:0] {
        RD_IDLE  = 2'd0,
        RD_WAIT  = 2'd1,
        RD_DRIVE = 2'd2
    } rd_state_e;

endpackage

// File: rtl/sram_byte_array.sv
// Word-addressed storage split into independent byte lanes: per-lane write
// enables, asynchronous read so the responder can capture data on the same edge.
module sram_byte_array
    import sram_pkg::*;
#(
    parameter int AW = 16
) (
    input  logic                   clk,
    input  logic [AW-1:0]          addr,
    input  logic [NUM_LANES-1:0]   lane_we,
    input  logic [SRAM_DATA_W-1:0] wdata,
    output logic [SRAM_DATA_W-1:0] rdata
);

    generate
        for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            logic [LANE_W-1:0] mem [2**AW];

            always_ff @(posedge clk) begin
                if (lane_we[gi]) begin
                    mem[addr] <= wdata[gi*LANE_W +: LANE_W];
                end
            end

            assign rdata[gi*LANE_W +: LANE_W] = mem[addr];
        end
    endgenerate

endmodule

// File: rtl/sram_responder.sv
// Behavioural responder for the external SRAM: byte-masked writes, a read FSM
// with programmable latency, tri-state data drive and saturating access counters.
module sram_responder
    import sram_pkg::*;
#(
    parameter int ADDR_W   = SRAM_ADDR_W,
    parameter int DATA_W   = SRAM_DATA_W,
    parameter int MEM_AW   = 16,
    parameter int READ_LAT = 2,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] SRAM_ADDRIn,
    inout  wire  [DATA_W-1:0] SRAM_DQInOut,
    input  logic              SRAM_UB_NIn,
    input  logic              SRAM_LB_NIn,
    input  logic              SRAM_WE_NIn,
    input  logic              SRAM_CE_NIn,
    input  logic              SRAM_OE_NIn,
    output logic [CNT_W-1:0]  rdCountOut,
    output logic [CNT_W-1:0]  wrCountOut
);

    localparam logic [1:0] ST_IDLE  = RD_IDLE;
    localparam logic [1:0] ST_WAIT  = RD_WAIT;
    localparam logic [1:0] ST_DRIVE = RD_DRIVE;

    localparam int LAT = (READ_LAT < READ_LAT_MIN) ? READ_LAT_MIN :
                         (READ_LAT > READ_LAT_MAX) ? READ_LAT_MAX : READ_LAT;
    localparam logic [2:0] CNT_RELOAD = 3'(LAT - 1);
    localparam bit         LAT_ONE    = (LAT == 1);

    logic [1:0]           state_reg, state_next;
    logic [2:0]           cnt_reg, cnt_next;
    logic [MEM_AW-1:0]    addr_reg, addr_next;
    logic [DATA_W-1:0]    rdata_reg, rdata_next;
    logic [CNT_W-1:0]     rd_count_reg, wr_count_reg;

    logic [MEM_AW-1:0]    word_addr;
    logic                 wr, rd, addr_hit, restart, enter_drive, drive_ok;
    logic [NUM_LANES-1:0] lane_en_n, lane_we, lane_drive;
    logic [DATA_W-1:0]    mem_rdata;

    // Upper address bits are deliberately ignored so addresses alias modulo 2^MEM_AW.
    assign word_addr = SRAM_ADDRIn[MEM_AW-1:0];
    generate
        if (ADDR_W > MEM_AW) begin : g_alias
            logic unused_upper_addr;
            assign unused_upper_addr = ^SRAM_ADDRIn[ADDR_W-1:MEM_AW];
        end
    endgenerate

    assign wr       = ~SRAM_CE_NIn & ~SRAM_WE_NIn;
    assign rd       = ~SRAM_CE_NIn &  SRAM_WE_NIn & ~SRAM_OE_NIn;
    assign addr_hit = (word_addr == addr_reg);

    assign lane_en_n[LANE_HI] = SRAM_UB_NIn;
    assign lane_en_n[LANE_LO] = SRAM_LB_NIn;
    assign lane_we = {NUM_LANES{wr & ~rst}} & ~lane_en_n;

    sram_byte_array #(
        .AW (MEM_AW)
    ) u_array (
        .clk     (clk),
        .addr    (word_addr),
        .lane_we (lane_we),
        .wdata   (SRAM_DQInOut),
        .rdata   (mem_rdata)
    );

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        addr_next   = addr_reg;
        rdata_next  = rdata_reg;
        restart     = 1'b0;
        enter_drive = 1'b0;
        if (wr || !rd) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE:  restart = 1'b1;
                ST_WAIT: begin
                    if (!addr_hit) begin
                        restart = 1'b1;
                    end else if (cnt_reg == 3'd1) begin
                        state_next  = ST_DRIVE;
                        rdata_next  = mem_rdata;
                        enter_drive = 1'b1;
                    end else begin
                        cnt_next = cnt_reg - 3'd1;
                    end
                end
                ST_DRIVE: restart = !addr_hit;
                default:  state_next = ST_IDLE;
            endcase
            // A new or changed address always pays the full latency again.
            if (restart) begin
                addr_next = word_addr;
                if (LAT_ONE) begin
                    state_next  = ST_DRIVE;
                    rdata_next  = mem_rdata;
                    enter_drive = 1'b1;
                end else begin
                    state_next = ST_WAIT;
                    cnt_next   = CNT_RELOAD;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= '0;
            addr_reg     <= '0;
            rdata_reg    <= '0;
            rd_count_reg <= '0;
            wr_count_reg <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            addr_reg  <= addr_next;
            rdata_reg <= rdata_next;
            if (enter_drive && rd_count_reg != '1) begin
                rd_count_reg <= rd_count_reg + 1'b1;
            end
            if (wr && wr_count_reg != '1) begin
                wr_count_reg <= wr_count_reg + 1'b1;
            end
        end
    end

    assign rdCountOut = rd_count_reg;
    assign wrCountOut = wr_count_reg;

    // Drive is released combinationally the moment rd drops or the address moves.
    assign drive_ok = (state_reg == ST_DRIVE) & rd & addr_hit;
    generate
        for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_dq
            assign lane_drive[gi] = drive_ok & ~lane_en_n[gi];
            assign SRAM_DQInOut[gi*LANE_W +: LANE_W] =
                lane_drive[gi] ? rdata_reg[gi*LANE_W +: LANE_W] : {LANE_W{1'bz}};
        end
    endgenerate

endmodule

// File: tb/tb_sram_responder.sv
// Directed bench for sram_responder (READ_LAT=2, MEM_AW=16); the data bus is
// pulled up so a released lane reads back as all-ones.
module tb_sram_responder;

    localparam logic [15:0] BUS_FLOAT = 16'hFFFF;

    logic        clk = 1'b0;
    logic        rst;
    logic [17:0] addr;
    tri1  [15:0] dq;
    logic [15:0] drv_data;
    logic        drv_en;
    logic        ub_n, lb_n, we_n, ce_n, oe_n;
    logic [15:0] rd_cnt, wr_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    assign dq = drv_en ? drv_data : 16'hzzzz;

    always #5 clk = ~clk;

    sram_responder dut (
        .clk          (clk),
        .rst          (rst),
        .SRAM_ADDRIn  (addr),
        .SRAM_DQInOut (dq),
        .SRAM_UB_NIn  (ub_n),
        .SRAM_LB_NIn  (lb_n),
        .SRAM_WE_NIn  (we_n),
        .SRAM_CE_NIn  (ce_n),
        .SRAM_OE_NIn  (oe_n),
        .rdCountOut   (rd_cnt),
        .wrCountOut   (wr_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        n_tests++;
        assert (observed === expected)
            $display("[TB] %s observed=%h expected=%h", tag, observed, expected);
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic bus_idle();
        ce_n = 1'b1; we_n = 1'b1; oe_n = 1'b1; ub_n = 1'b0; lb_n = 1'b0; drv_en = 1'b0;
    endtask

    task automatic bus_write(input logic [17:0] a, input logic [15:0] d, input logic ub, input logic lb);
        addr = a; drv_data = d; drv_en = 1'b1;
        ce_n = 1'b0; we_n = 1'b0; oe_n = 1'b1; ub_n = ub; lb_n = lb;
        tick();
        bus_idle();
    endtask

    task automatic bus_read(input logic [17:0] a);
        addr = a; drv_en = 1'b0;
        ce_n = 1'b0; we_n = 1'b1; oe_n = 1'b0; ub_n = 1'b0; lb_n = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held for two edges with a write asserted on the bus
        rst = 1'b1; addr = 18'h00007; drv_data = 16'h1234; drv_en = 1'b1;
        ce_n = 1'b0; we_n = 1'b0; oe_n = 1'b1; ub_n = 1'b0; lb_n = 1'b0;
        tick(); tick();
        rst = 1'b0;
        bus_idle();
        #1;
        check("reset_rd_count", rd_cnt, 16'h0000);
        check("reset_wr_count", wr_cnt, 16'h0000);
        check("reset_dq_float", dq, BUS_FLOAT);

        // Word 0x7 must still hold its initial zero
        bus_read(18'h00007);
        tick(); tick();
        check("no_write_in_reset", dq, 16'h0000);
        check("rd_count_1", rd_cnt, 16'd1);
        bus_idle(); tick();

        // Full write then read with latency 2
        bus_write(18'h00012, 16'hBEEF, 1'b0, 1'b0);
        check("wr_count_1", wr_cnt, 16'd1);
        bus_read(18'h00012);
        #1;
        check("rd_before_e0", dq, BUS_FLOAT);
        tick();
        check("rd_after_e0", dq, BUS_FLOAT);
        tick();
        check("rd_after_e1", dq, 16'hBEEF);
        check("rd_count_2", rd_cnt, 16'd2);
        tick();
        check("rd_hold", dq, 16'hBEEF);
        check("rd_count_hold", rd_cnt, 16'd2);
        bus_idle();
        #1;
        check("rd_release", dq, BUS_FLOAT);
        tick();

        // Upper-lane-only write, then masked lower lane on readback
        bus_write(18'h00012, 16'h1234, 1'b0, 1'b1);
        check("wr_count_2", wr_cnt, 16'd2);
        bus_read(18'h00012);
        tick(); tick();
        check("lane_write_read", dq, 16'h12EF);
        check("rd_count_3", rd_cnt, 16'd3);
        lb_n = 1'b1;
        #1;
        check("lane_lo_float", dq, 16'h12FF);
        bus_idle(); tick();

        // Address change while waiting restarts the latency
        bus_write(18'h00013, 16'hC0DE, 1'b0, 1'b0);
        check("wr_count_3", wr_cnt, 16'd3);
        bus_read(18'h00012);
        tick();
        addr = 18'h00013;
        #1;
        check("restart_chg", dq, BUS_FLOAT);
        tick();
        check("restart_e1", dq, BUS_FLOAT);
        tick();
        check("restart_e2", dq, 16'hC0DE);
        check("rd_count_4", rd_cnt, 16'd4);
        // Address change while driving releases at once and waits again
        addr = 18'h00012;
        #1;
        check("drive_addr_chg", dq, BUS_FLOAT);
        tick();
        check("drive_rewait", dq, BUS_FLOAT);
        tick();
        check("drive_new_data", dq, 16'h12EF);
        check("rd_count_5", rd_cnt, 16'd5);
        bus_idle(); tick();

        // Aliased write, then a masked write during DRIVE
        bus_write(18'h10005, 16'h5A5A, 1'b0, 1'b0);
        check("wr_count_4", wr_cnt, 16'd4);
        bus_read(18'h00005);
        tick(); tick();
        check("alias_read", dq, 16'h5A5A);
        check("rd_count_6", rd_cnt, 16'd6);
        we_n = 1'b0; ub_n = 1'b1; lb_n = 1'b1;
        #1;
        check("wr_in_drive_release", dq, BUS_FLOAT);
        tick();
        check("masked_wr_counted", wr_cnt, 16'd5);
        we_n = 1'b1; ub_n = 1'b0; lb_n = 1'b0;
        #1;
        check("fsm_idle_after_wr", dq, BUS_FLOAT);
        tick();
        check("reread_e0", dq, BUS_FLOAT);
        tick();
        check("masked_wr_kept", dq, 16'h5A5A);
        check("rd_count_7", rd_cnt, 16'd7);

        // Reset in the middle of a driven read
        rst = 1'b1;
        #1;
        check("rst_sync_hold", dq, 16'h5A5A);
        tick();
        check("rst_release", dq, BUS_FLOAT);
        check("rst_rd_count", rd_cnt, 16'h0000);
        check("rst_wr_count", wr_cnt, 16'h0000);
        rst = 1'b0;
        bus_idle(); tick();

        // 2^16+3 masked writes: counter saturates and holds
        addr = 18'h00000; ce_n = 1'b0; we_n = 1'b0; ub_n = 1'b1; lb_n = 1'b1;
        repeat (65534) tick();
        check("wr_cnt_near_sat", wr_cnt, 16'hFFFE);
        tick();
        check("wr_cnt_sat", wr_cnt, 16'hFFFF);
        repeat (4) tick();
        check("wr_cnt_hold", wr_cnt, 16'hFFFF);
        check("rd_cnt_untouched", rd_cnt, 16'h0000);
        bus_idle(); tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_responder.md
# sram_responder

Cycle-accurate behavioural model of the 16-bit external SRAM: the responder end of the SRAM bus driven by the CPU's SRAM controller. It is used in simulation and in the board-less testbench. It samples the controller's address and active-low strobes every clock, performs byte-masked writes, and drives the bidirectional data bus after a programmable read latency. Saturating access counters are exposed for verification.

## Interface
Parameters:
- ADDR_W, 18, width of SRAM address bus
- DATA_W, 16, width of data bus (two byte lanes; fixed at 16)
- MEM_AW, 16, implemented word-address bits; upper ADDR_W-MEM_AW bits ignored (aliasing)
- READ_LAT, 2, cycles from first sampled read request to DQ valid; legal range 1..7
- CNT_W, 16, width of access counters

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- SRAM_ADDRIn  in  ADDR_W  word address
- SRAM_DQInOut  inout  DATA_W  data bus; responder drives only during read DRIVE
- SRAM_UB_NIn  in  1  upper-byte (15:8) enable, active low
- SRAM_LB_NIn  in  1  lower-byte (7:0) enable, active low
- SRAM_WE_NIn  in  1  write enable, active low
- SRAM_CE_NIn  in  1  chip enable, active low
- SRAM_OE_NIn  in  1  output enable, active low
- rdCountOut  out  CNT_W  completed reads (entries into DRIVE), saturating
- wrCountOut  out  CNT_W  write cycles performed, saturating

## Operation
- Conditions, evaluated on sampled inputs:
  - wr = ~CE_N & ~WE_N
  - rd = ~CE_N & WE_N & ~OE_N
  - WE_N has priority over OE_N.
- Write: on an edge with wr, mem[addr[MEM_AW-1:0]] is updated per lane.
  - [15:8] is updated iff ~UB_N; [7:0] is updated iff ~LB_N.
  - Both masks high: no update, but wrCountOut still increments.
- Read FSM states: IDLE, WAIT, DRIVE.
  - IDLE: on rd, latch addr. If READ_LAT==1, go to DRIVE and load rdata=mem[addr]. Otherwise go to WAIT with cnt=READ_LAT-1.
  - WAIT: if !rd, go to IDLE. If addr differs from the latched addr, relatch and reload cnt=READ_LAT-1 (restart). Otherwise decrement cnt; at cnt==1, go to DRIVE and load rdata.
  - DRIVE: if !rd, go to IDLE. If addr changes, relatch and restart the latency: go to WAIT, or to DRIVE with new rdata if READ_LAT==1.
  - Entering DRIVE increments rdCountOut.
  - wr in any state forces IDLE; the write is still performed.
- DQ drive (combinational): lane [15:8] = rdata[15:8] when state==DRIVE & rd & addr==latched & ~UB_N; otherwise Z. Lane [7:0] follows the same rule with LB_N.
- Write during a pending read to the same address: the read is aborted. A later read returns the new data.
- Counters saturate at all-ones; they do not wrap.
- Memory contents are not reset. Simulation initialises the array to 0 at time zero.

## Timing
- Reset, on an edge with rst: state=IDLE, cnt=0, rdata=0, rdCountOut=0, wrCountOut=0, DQ=Z. rst overrides wr/rd in the same edge; no write is performed.
- Reset mid-read: DQ is released the cycle after the reset edge.
- Write latency: data is stored at the sampling edge. A read of that address requested at the next edge returns the new value.
- Read latency: rd is first sampled at edge E0. DQ is valid from just after edge E0+READ_LAT-1 and held while rd and the address are stable.
- DQ release: combinational and same-cycle when rd drops or the address changes. The controller never sees a stale drive.
- Back-to-back reads at different addresses: each incurs the full READ_LAT.
- Address wrap: addr and addr+2^MEM_AW alias to the same word.

## Structure
- Shared package sram_pkg holds:
  - the read-state enum (IDLE, WAIT, DRIVE)
  - default ADDR_W/DATA_W
  - READ_LAT bounds
  - the byte-lane index constants
- The controller imports the same package.
- Sub-module sram_byte_array: 2^MEM_AW x 16 array with two lane write enables and an asynchronous read port. The FSM, counters and tri-state drive live in sram_responder.

## Test plan
- Reset with rst=1 for 2 cycles while CE_N=0, WE_N=0 -> no write; counters 0; DQ=Z.
- Write 0xBEEF to 0x00012 (UB_N=LB_N=0), then read with READ_LAT=2 -> DQ=Z for 1 cycle, 0xBEEF from the 2nd cycle; rdCountOut=1, wrCountOut=1.
- Lane write 0x12xx with UB_N=0, LB_N=1 to 0x00012 -> readback 0x12EF. Read with LB_N=1 -> [7:0]=Z.
- Address change in WAIT (0x00012 to 0x00013 at E0+1) -> latency restarts; DQ valid from E0+2 (READ_LAT=2) with mem[0x13].
- Alias: write 0x5A5A to 0x10005 (MEM_AW=16), read 0x00005 -> 0x5A5A. Write asserted during DRIVE -> DQ=Z same cycle, FSM IDLE.
- 2^CNT_W+3 writes -> wrCountOut holds 0xFFFF.
